// File: rtl/stream_fifo.sv
// Synchronous valid/ready stream FIFO with occupancy count,
// almost-full/almost-empty flags, flush and high-water mark.
module stream_fifo #(
  parameter int WIDTH     = 248,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [WIDTH-1:0]           s_data,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [WIDTH-1:0]           m_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH):0]     hwm
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("stream_fifo: DEPTH must be a power of 2 and >= 2");
  end
  if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
    $error("stream_fifo: AF_THRESH out of range 1..DEPTH");
  end
  if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_ae
    $error("stream_fifo: AE_THRESH out of range 0..DEPTH-1");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [CW-1:0]    wptr;
  logic [CW-1:0]    rptr;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    hwm_q;
  logic [CW-1:0]    cnt_nxt;
  logic [CW-1:0]    hwm_nxt;
  logic             wr_fire;
  logic             rd_fire;

  // Handshake outputs come only from the registered count.
  assign s_ready      = (cnt != CW'(DEPTH));
  assign m_valid      = (cnt != '0);
  assign wr_fire      = s_valid && s_ready;
  assign rd_fire      = m_valid && m_ready;
  assign m_data       = mem[rptr[AW-1:0]];
  assign count        = cnt;
  assign hwm          = hwm_q;
  assign almost_full  = (cnt >= CW'(AF_THRESH));
  assign almost_empty = (cnt <= CW'(AE_THRESH));

  always_comb begin
    cnt_nxt = cnt;
    unique case ({wr_fire, rd_fire})
      2'b10:   cnt_nxt = cnt + CW'(1);
      2'b01:   cnt_nxt = cnt - CW'(1);
      default: cnt_nxt = cnt;
    endcase
    hwm_nxt = (cnt_nxt > hwm_q) ? cnt_nxt : hwm_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      cnt   <= '0;
      hwm_q <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      cnt   <= '0;
      hwm_q <= '0;
    end else begin
      if (wr_fire) wptr <= wptr + CW'(1);
      if (rd_fire) rptr <= rptr + CW'(1);
      cnt   <= cnt_nxt;
      hwm_q <= hwm_nxt;
    end
  end

  // Storage has no reset; a flushed or reset cycle never writes.
  always_ff @(posedge clk) begin
    if (wr_fire && !flush && !rst)
      mem[wptr[AW-1:0]] <= s_data;
  end

endmodule

// File: tb/tb_stream_fifo.sv
// Bench for stream_fifo: directed test-plan steps plus randomized
// traffic, all checked against a queue-based reference model.
module tb_stream_fifo;

  localparam int W = 248;
  localparam int D = 16;
  localparam int CW = $clog2(D) + 1;

  logic          clk;
  logic          rst;
  logic          flush;
  logic          s_valid;
  logic          s_ready;
  logic [W-1:0]  s_data;
  logic          m_valid;
  logic          m_ready;
  logic [W-1:0]  m_data;
  logic [CW-1:0] count;
  logic          almost_full;
  logic          almost_empty;
  logic [CW-1:0] hwm;

  stream_fifo #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .count(count), .almost_full(almost_full),
    .almost_empty(almost_empty), .hwm(hwm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [W-1:0] q[$];
  int           m_hwm = 0;
  logic         last_wr = 1'b0;

  task automatic chk(input string tag,
                     input logic [255:0] obs,
                     input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] rnd();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v[W-1:0];
  endfunction

  // Reference: FIFO as a queue, flags from its size.
  task automatic model_edge();
    bit rdf;
    bit wrf;
    last_wr = 1'b0;
    if (rst || flush) begin
      q.delete();
      m_hwm = 0;
    end else begin
      rdf = (q.size() > 0) && m_ready;
      wrf = s_valid && (q.size() < D);
      if (rdf) void'(q.pop_front());
      if (wrf) q.push_back(s_data);
      last_wr = wrf;
      if (q.size() > m_hwm) m_hwm = q.size();
    end
  endtask

  task automatic check_all();
    chk("count", count, q.size());
    chk("m_valid", m_valid, q.size() != 0);
    chk("s_ready", s_ready, q.size() != D);
    chk("almost_full", almost_full, q.size() >= D - 2);
    chk("almost_empty", almost_empty, q.size() <= 1);
    chk("hwm", hwm, m_hwm);
    if (q.size() != 0) chk("m_data", m_data, q[0]);
  endtask

  task automatic cyc(input logic r, input logic f, input logic v,
                     input logic [W-1:0] d, input logic mr);
    rst = r; flush = f; s_valid = v; s_data = d; m_ready = mr;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  // Upstream must hold a stalled word stable.
  logic         p_hold;
  logic [W-1:0] p_data;
  always @(posedge clk) begin
    if (p_hold) begin
      n_cmp++;
      assert (s_valid === 1'b1 && s_data === p_data) else begin
        n_err++;
        $error("FAIL protocol_hold: got v=%0b d=%0h want v=1 d=%0h",
               s_valid, s_data, p_data);
      end
    end
    p_hold <= s_valid && !s_ready && !rst && !flush;
    p_data <= s_data;
  end

  initial begin
    logic         cv;
    logic [W-1:0] cd;
    logic [W-1:0] z;
    logic [W-1:0] k;
    z = '0;
    p_hold = 1'b0;
    rst = 1'b1; flush = 1'b0; s_valid = 1'b0;
    s_data = '0; m_ready = 1'b0;

    cyc(1, 0, 0, z, 0);
    chk("rst_count", count, 0);
    chk("rst_sready", s_ready, 1);
    chk("rst_ae", almost_empty, 1);

    for (int i = 1; i <= D; i++) begin
      k = W'(i);
      cyc(0, 0, 1, k, 0);
    end
    chk("fill_sready", s_ready, 0);
    chk("fill_hwm", hwm, 16);
    for (int i = 0; i < D; i++) cyc(0, 0, 0, z, 1);
    chk("drain_mvalid", m_valid, 0);
    chk("drain_ae", almost_empty, 1);

    k = W'(8'hAB);
    cyc(0, 0, 1, k, 1);
    chk("lat_mvalid", m_valid, 1);
    chk("lat_mdata", m_data, 8'hAB);
    cyc(0, 0, 0, z, 1);
    chk("lat_count", count, 0);

    for (int i = 0; i < D; i++) cyc(0, 0, 1, rnd(), 0);
    k = W'(8'h77);
    cyc(0, 0, 1, k, 1);
    chk("full_rd_count", count, 15);
    chk("full_rd_sready", s_ready, 1);
    cyc(0, 0, 1, k, 0);
    chk("held_accept", count, 16);

    cyc(0, 1, 0, z, 0);
    for (int i = 0; i < 8; i++) cyc(0, 0, 1, rnd(), 0);
    for (int i = 0; i < 40; i++) cyc(0, 0, 1, rnd(), 1);
    chk("stream_count", count, 8);
    chk("stream_hwm", hwm, 8);

    for (int i = 0; i < 4; i++) cyc(0, 0, 1, rnd(), 0);
    for (int i = 0; i < 7; i++) cyc(0, 0, 0, z, 1);
    chk("pre_flush_hwm", hwm, 12);
    chk("pre_flush_cnt", count, 5);
    k = W'(8'hEE);
    cyc(0, 1, 1, k, 1);
    chk("flush_count", count, 0);
    chk("flush_hwm", hwm, 0);
    chk("flush_mvalid", m_valid, 0);
    chk("flush_sready", s_ready, 1);

    for (int i = 0; i < 9; i++) cyc(0, 0, 1, rnd(), 0);
    cyc(1, 0, 1, rnd(), 1);
    chk("mid_rst_count", count, 0);
    chk("mid_rst_ae", almost_empty, 1);
    k = W'(8'h55);
    cyc(0, 0, 1, k, 0);
    chk("post_rst_data", m_data, 8'h55);
    cyc(0, 0, 0, z, 1);

    cv = 1'b0;
    cd = '0;
    for (int i = 0; i < 800; i++) begin
      logic r;
      logic f;
      if (!(cv && !last_wr)) begin
        cv = ($urandom_range(0, 99) < 60);
        cd = rnd();
      end
      r = ($urandom_range(0, 199) == 0);
      f = ($urandom_range(0, 49) == 0);
      cyc(r, f, cv, cd, $urandom_range(0, 99) < 45);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
